// File: rtl/run_controller.sv
// Run sequencer for the 9-bit-ISA core: holds the core in reset until start,
// runs it while counting cycles, and stops on halt pattern, PC 8'hFF or cycle limit.
module run_controller #(
  parameter int HALT_RUN   = 2,
  parameter int MAX_CYCLES = 4096,
  parameter int CLR_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_pc,
  input  logic [8:0]  i_mach_code,
  output logic        o_core_reset,
  output logic        o_core_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [15:0] o_cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_start_q;
  logic [3:0]  r_clr_cnt;
  logic [3:0]  r_zero_cnt;
  logic [15:0] r_cycle_count;
  logic        r_done;
  logic        r_timeout;
  logic        r_core_reset;
  logic        r_core_en;
  logic        r_busy;

  logic        w_start_rise;
  logic        w_is_zero;
  logic [4:0]  w_zero_sum;
  logic        w_halt;
  logic        w_limit;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_is_zero    = (i_mach_code == 9'd0);
  assign w_zero_sum   = {1'b0, r_zero_cnt} + {4'd0, w_is_zero};
  assign w_halt       = (w_zero_sum >= 5'(HALT_RUN)) || (i_pc == 8'hFF);
  assign w_limit      = (({1'b0, r_cycle_count} + 17'd1) == 17'(MAX_CYCLES));

  // Next-state decode; halt and limit are both evaluated on the current RUN cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) w_next = S_CLEAR;
        else              w_next = S_IDLE;
      end
      S_CLEAR: begin
        if (r_clr_cnt == 4'd0) w_next = S_RUN;
        else                   w_next = S_CLEAR;
      end
      S_RUN: begin
        if (w_halt || w_limit) w_next = S_DONE;
        else                   w_next = S_RUN;
      end
      S_DONE: begin
        if (w_start_rise) w_next = S_CLEAR;
        else              w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counters and outputs; control outputs are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_clr_cnt     <= 4'd0;
      r_zero_cnt    <= 4'd0;
      r_cycle_count <= 16'd0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_core_reset  <= 1'b1;
      r_core_en     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_start_q    <= i_start;
      r_core_reset <= (w_next == S_IDLE) || (w_next == S_CLEAR);
      r_core_en    <= (w_next == S_RUN);
      r_busy       <= (w_next == S_CLEAR) || (w_next == S_RUN);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_rise) begin
            r_clr_cnt     <= 4'(CLR_CYCLES - 1);
            r_zero_cnt    <= 4'd0;
            r_cycle_count <= 16'd0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt != 4'd0) r_clr_cnt <= r_clr_cnt - 4'd1;
          r_zero_cnt    <= 4'd0;
          r_cycle_count <= 16'd0;
          r_done        <= 1'b0;
          r_timeout     <= 1'b0;
        end
        S_RUN: begin
          if (r_cycle_count != 16'hFFFF) r_cycle_count <= r_cycle_count + 16'd1;
          r_zero_cnt <= w_is_zero ? (r_zero_cnt + 4'd1) : 4'd0;
          if (w_halt || w_limit) begin
            r_done    <= 1'b1;
            r_timeout <= w_limit && !w_halt;
          end
        end
        default: begin
          r_clr_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign o_core_reset  = r_core_reset;
  assign o_core_en     = r_core_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus random programs
// checked against a per-run reference model of halt/timeout rules.
module tb_run_controller;

  localparam int HALT_RUN   = 2;
  localparam int MAX_CYCLES = 20;
  localparam int CLR_CYCLES = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pc;
  logic [8:0]  mach_code;
  logic        core_reset;
  logic        core_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_checks;
  int n_fail;

  logic [8:0] prog_mc [0:63];
  logic [7:0] prog_pc [0:63];

  run_controller #(
    .HALT_RUN  (HALT_RUN),
    .MAX_CYCLES(MAX_CYCLES),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_pc         (pc),
    .i_mach_code  (mach_code),
    .o_core_reset (core_reset),
    .o_core_en    (core_en),
    .o_busy       (busy),
    .o_done       (done),
    .o_timeout    (timeout),
    .o_cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scan the program as the core would present it, one instruction per RUN cycle.
  function automatic void ref_model(output int end_k, output bit exp_to);
    int  zrun;
    bit  halt;
    bit  lim;
    zrun   = 0;
    end_k  = 64;
    exp_to = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      zrun = (prog_mc[k-1] == 9'd0) ? zrun + 1 : 0;
      halt = (zrun >= HALT_RUN) || (prog_pc[k-1] == 8'hFF);
      lim  = (k == MAX_CYCLES);
      if (halt || lim) begin
        end_k  = k;
        exp_to = lim && !halt;
        return;
      end
    end
  endfunction

  task automatic fill_nonzero();
    for (int i = 0; i < 64; i++) begin
      prog_mc[i] = 9'($urandom_range(1, 511));
      prog_pc[i] = 8'(i);
    end
  endtask

  // Called right after the edge that accepted start; walks CLEAR and RUN to completion.
  task automatic run_body(input string name, input int stop_at);
    int end_k;
    bit exp_to;
    check({name, "_clr_busy"},  32'(busy), 32'd1);
    check({name, "_clr_creset"}, 32'(core_reset), 32'd1);
    check({name, "_clr_en"},    32'(core_en), 32'd0);
    check({name, "_clr_done"},  32'(done), 32'd0);
    check({name, "_clr_to"},    32'(timeout), 32'd0);
    check({name, "_clr_cnt"},   32'(cycle_count), 32'd0);
    for (int i = 1; i < CLR_CYCLES; i++) begin
      step();
      check({name, "_clr_hold_en"}, 32'(core_en), 32'd0);
      check({name, "_clr_hold_creset"}, 32'(core_reset), 32'd1);
    end
    mach_code = prog_mc[0];
    pc        = prog_pc[0];
    step();
    check({name, "_run_en"},     32'(core_en), 32'd1);
    check({name, "_run_creset"}, 32'(core_reset), 32'd0);
    check({name, "_run_busy"},   32'(busy), 32'd1);
    ref_model(end_k, exp_to);
    for (int k = 1; k <= end_k; k++) begin
      mach_code = prog_mc[k-1];
      pc        = prog_pc[k-1];
      step();
      if (k < end_k) begin
        check({name, "_run_notdone"}, 32'(done), 32'd0);
        check({name, "_run_count"},   32'(cycle_count), 32'(k));
      end else begin
        check({name, "_end_done"},  32'(done), 32'd1);
        check({name, "_end_en"},    32'(core_en), 32'd0);
        check({name, "_end_busy"},  32'(busy), 32'd0);
        check({name, "_end_creset"}, 32'(core_reset), 32'd0);
        check({name, "_end_to"},    32'(timeout), 32'(exp_to));
        check({name, "_end_count"}, 32'(cycle_count), 32'(end_k));
      end
      if (k == stop_at) return;
    end
  endtask

  task automatic start_pulse();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b1;
    pc        = 8'd0;
    mach_code = 9'd1;

    // Reset with start high, then release: start counts as a rising edge.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_creset", 32'(core_reset), 32'd1);
      check("rst_en",     32'(core_en), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_to",     32'(timeout), 32'd0);
      check("rst_cnt",    32'(cycle_count), 32'd0);
    end
    fill_nonzero();
    rst_n = 1'b1;
    step();
    run_body("tmo", 0);
    check("tmo_flag",  32'(timeout), 32'd1);
    check("tmo_count", 32'(cycle_count), 32'd20);

    // Start still held high: no restart.
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_done", 32'(done), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_to",   32'(timeout), 32'd1);
    end

    // Drop start one cycle and raise: ten nonzero then two zeros.
    fill_nonzero();
    prog_mc[10] = 9'd0;
    prog_mc[11] = 9'd0;
    start_pulse();
    run_body("zero2", 0);
    check("zero2_count", 32'(cycle_count), 32'd12);
    check("zero2_to",    32'(timeout), 32'd0);

    // Interleaved zeros never halt; PC 8'hFF does.
    for (int i = 0; i < 64; i++) begin
      prog_mc[i] = (i % 2 == 0) ? 9'd0 : ((i % 4 == 1) ? 9'h1A5 : 9'h003);
      prog_pc[i] = 8'(i);
    end
    prog_pc[10] = 8'hFF;
    start_pulse();
    run_body("pcff", 0);
    check("pcff_count", 32'(cycle_count), 32'd11);
    check("pcff_to",    32'(timeout), 32'd0);

    // Halt and limit on the same cycle: halt wins.
    fill_nonzero();
    prog_mc[18] = 9'd0;
    prog_mc[19] = 9'd0;
    start_pulse();
    run_body("tie", 0);
    check("tie_count", 32'(cycle_count), 32'd20);
    check("tie_to",    32'(timeout), 32'd0);

    // Random programs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 64; i++) begin
        prog_mc[i] = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        prog_pc[i] = ($urandom_range(0, 29) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      end
      start_pulse();
      run_body("rand", 0);
    end

    // Reset mid-RUN at cycle_count 7.
    fill_nonzero();
    start_pulse();
    run_body("mid", 7);
    check("mid_pre_count", 32'(cycle_count), 32'd7);
    rst_n = 1'b0;
    step();
    check("mid_creset", 32'(core_reset), 32'd1);
    check("mid_en",     32'(core_en), 32'd0);
    check("mid_cnt",    32'(cycle_count), 32'd0);
    check("mid_done",   32'(done), 32'd0);
    check("mid_busy",   32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy",   32'(busy), 32'd0);
    check("idle_creset", 32'(core_reset), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
